// File: rtl/ss_multi_queue_if.sv
// Push/pop bundle of the superscalar circular queue.
// valid/ready: lane i transfers when i_push_valid[i] and o_push_accept[i] are both high in the same cycle.
interface ss_multi_queue_if #(
   parameter int SS    = 2,
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int PCW = $clog2(SS + 1);
   localparam int OCW = $clog2(DEPTH + 1);

   logic                      i_flush;
   logic [SS-1:0]             i_push_valid;
   logic [SS-1:0][WIDTH-1:0]  i_push_data;
   logic [SS-1:0]             o_push_accept;
   logic [PCW-1:0]            i_pop_count;
   logic [SS-1:0]             o_out_valid;
   logic [SS-1:0][WIDTH-1:0]  o_out_data;
   logic [OCW-1:0]            o_occupancy;
   logic [OCW-1:0]            o_free_slots;
   logic                      o_full;
   logic                      o_empty;

   modport slave (
      input  i_flush, i_push_valid, i_push_data, i_pop_count,
      output o_push_accept, o_out_valid, o_out_data, o_occupancy, o_free_slots, o_full, o_empty
   );

   modport master (
      output i_flush, i_push_valid, i_push_data, i_pop_count,
      input  o_push_accept, o_out_valid, o_out_data, o_occupancy, o_free_slots, o_full, o_empty
   );
endinterface

// File: rtl/ss_multi_queue.sv
// Superscalar circular queue: 0..SS pushes and 0..SS pops per cycle, single-cycle flush,
// optional preload with sequential indices for free-list use.
module ss_multi_queue #(
   parameter int SS        = 2,
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int INIT_MODE = 0,
   parameter int INIT_BASE = 0
) (
   input  logic               clk,
   input  logic               rst,
   ss_multi_queue_if.slave    q
);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCW = $clog2(DEPTH + 1);
   localparam int PCW = $clog2(SS + 1);
   localparam logic [OCW-1:0] DEPTH_O = OCW'(DEPTH);
   localparam logic [IW:0]    DEPTH_I = (IW + 1)'(DEPTH);

   logic [WIDTH-1:0]          r_mem [DEPTH];
   logic [IW-1:0]             r_head;
   logic [IW-1:0]             r_tail;
   logic [OCW-1:0]            r_occ;

   logic [PCW-1:0]            w_push_cnt;
   logic [OCW-1:0]            w_free;
   logic [OCW-1:0]            w_acc;
   logic [OCW-1:0]            w_pcnt;
   logic [SS-1:0]             w_push_accept;
   logic [SS-1:0][IW-1:0]     w_wr_idx;
   logic [SS-1:0][IW-1:0]     w_rd_idx;

   // Offsets never exceed DEPTH, so one conditional subtract keeps non-power-of-two depths correct.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [IW:0] off);
      logic [IW:0] s;
      s = {1'b0, base} + off;
      if (s >= DEPTH_I) s = s - DEPTH_I;
      return s[IW-1:0];
   endfunction

   // Only the unbroken run of valid lanes from lane 0 counts; lanes past the first gap are ignored.
   always_comb begin
      logic run;
      w_push_cnt = '0;
      run        = 1'b1;
      for (int i = 0; i < SS; i++) begin
         if (run && q.i_push_valid[i]) w_push_cnt = w_push_cnt + PCW'(1);
         else                          run        = 1'b0;
      end
   end

   // Space freed by a same-cycle pop is deliberately not reused until the next cycle.
   assign w_free = DEPTH_O - r_occ;
   assign w_acc  = (OCW'(w_push_cnt) < w_free) ? OCW'(w_push_cnt) : w_free;
   assign w_pcnt = (OCW'(q.i_pop_count) < r_occ) ? OCW'(q.i_pop_count) : r_occ;

   for (genvar g = 0; g < SS; g++) begin : g_lane
      assign w_wr_idx[g]      = wrap_add(r_tail, (IW + 1)'(g));
      assign w_rd_idx[g]      = wrap_add(r_head, (IW + 1)'(g));
      assign w_push_accept[g] = (OCW'(g) < w_acc) && !q.i_flush && !rst;
      assign q.o_out_valid[g] = (OCW'(g) < r_occ);
      assign q.o_out_data[g]  = r_mem[w_rd_idx[g]];
   end

   assign q.o_push_accept = w_push_accept;
   assign q.o_occupancy   = r_occ;
   assign q.o_free_slots  = w_free;
   assign q.o_full        = (r_occ == DEPTH_O);
   assign q.o_empty       = (r_occ == '0);

   always_ff @(posedge clk) begin
      if (rst || q.i_flush) begin
         r_head <= '0;
         r_tail <= '0;
         if (INIT_MODE == 1) begin
            r_occ <= DEPTH_O;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= WIDTH'(INIT_BASE + i);
         end else begin
            r_occ <= '0;
         end
      end else begin
         for (int i = 0; i < SS; i++) begin
            if (w_push_accept[i]) r_mem[w_wr_idx[i]] <= q.i_push_data[i];
         end
         r_head <= wrap_add(r_head, (IW + 1)'(w_pcnt));
         r_tail <= wrap_add(r_tail, (IW + 1)'(w_acc));
         r_occ  <= r_occ + w_acc - w_pcnt;
      end
   end
endmodule
